dmem_resp: RTL and testbench

Data-side memory responder for the core's data port. It answers the core's load/store accesses (`dat_a`/`dat_we`/`dat_wd`/`dat_re`/`dat_rd`) from a synchronous byte-writable SRAM with one-cycle read latency, and from a small MMIO page that holds a free-running timer, a compare interrupt and a `tohost` completion register. It sits at top level beside the instruction SRAM and is the block the simulation bench watches to decide pass/fail.

---
 rtl/dmem_resp_if.sv | 19 +
 rtl/dmem_resp.sv | 139 +++++++++++++
 tb/tb_dmem_resp.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_resp_if.sv
// rtl/dmem_resp_if.sv - data-port bus between the core and the data memory responder
interface dmem_resp_if;
  logic [15:0] dat_a;
  logic [3:0]  dat_we;
  logic [31:0] dat_wd;
  logic [3:0]  dat_re;
  logic [31:0] dat_rd;
  logic        bus_err;

  modport master (
    output dat_a, dat_we, dat_wd, dat_re,
    input  dat_rd, bus_err
  );

  modport slave (
    input  dat_a, dat_we, dat_wd, dat_re,
    output dat_rd, bus_err
  );
endinterface

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - data memory responder: byte-writable SRAM plus timer/tohost MMIO page
module dmem_resp #(
  parameter int          DEPTH     = 4096,
  parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
  input  logic        clk,
  input  logic        rstn,
  dmem_resp_if.slave  bus,
  output logic        irq_timer,
  output logic        done,
  output logic [31:0] tohost
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Expand four byte-lane enables into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] en);
    return {{8{en[3]}}, {8{en[2]}}, {8{en[1]}}, {8{en[0]}}};
  endfunction

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_sram_q;
  logic        r_sel_sram;
  logic [31:0] r_rmask;
  logic [31:0] r_mmio_q;
  logic        r_bus_err;
  logic [31:0] r_mtime;
  logic [31:0] r_mtimecmp;
  logic [31:0] r_tohost;
  logic        r_pending;
  logic        r_done;

  logic        w_acc;
  logic        w_is_mmio;
  logic [13:0] w_idx;
  logic        w_in_range;
  logic [13:0] w_woff;
  logic        w_mapped;
  logic        w_sel_mtime;
  logic        w_sel_cmp;
  logic        w_sel_status;
  logic        w_sel_tohost;
  logic        w_err;
  logic [31:0] w_wmask;
  logic [31:0] w_rmask;
  logic [31:0] w_mtime_inc;
  logic [31:0] w_mtime_n;
  logic [31:0] w_cmp_n;
  logic [31:0] w_tohost_n;
  logic        w_set;
  logic        w_clr;
  logic [31:0] w_mmio_val;
  logic [31:0] w_mmio_rd;

  assign w_acc      = (|bus.dat_we) || (|bus.dat_re);
  assign w_is_mmio  = (bus.dat_a >= MMIO_BASE);
  assign w_idx      = bus.dat_a[15:2];
  assign w_in_range = !w_is_mmio && ({18'd0, w_idx} < 32'(DEPTH));
  // Word offset inside the MMIO page; only the first four words are populated.
  assign w_woff     = w_idx - MMIO_BASE[15:2];
  assign w_mapped   = w_is_mmio && (w_woff[13:2] == 12'd0);

  assign w_sel_mtime  = w_mapped && (w_woff[1:0] == 2'd0);
  assign w_sel_cmp    = w_mapped && (w_woff[1:0] == 2'd1);
  assign w_sel_status = w_mapped && (w_woff[1:0] == 2'd2);
  assign w_sel_tohost = w_mapped && (w_woff[1:0] == 2'd3);

  assign w_err   = w_acc && ((w_is_mmio && !w_mapped) || (!w_is_mmio && !w_in_range));
  assign w_wmask = lane_mask(bus.dat_we);
  assign w_rmask = lane_mask(bus.dat_re);

  // Written mtime lanes take the bus data, the rest keep counting.
  assign w_mtime_inc = r_mtime + 32'd1;
  assign w_mtime_n   = w_sel_mtime ? ((bus.dat_wd & w_wmask) | (w_mtime_inc & ~w_wmask))
                                   : w_mtime_inc;
  assign w_cmp_n     = w_sel_cmp ? ((bus.dat_wd & w_wmask) | (r_mtimecmp & ~w_wmask))
                                 : r_mtimecmp;
  assign w_tohost_n  = w_sel_tohost ? ((bus.dat_wd & w_wmask) | (r_tohost & ~w_wmask))
                                    : r_tohost;

  // Compare uses the mtime held this cycle; a zero compare value disarms the timer.
  assign w_set = (r_mtime == r_mtimecmp) && (r_mtimecmp != 32'd0);
  assign w_clr = w_sel_status && bus.dat_we[0] && bus.dat_wd[0];

  // MMIO read mux returns pre-edge register values.
  always_comb begin
    w_mmio_val = 32'd0;
    case (w_woff[1:0])
      2'd0:    w_mmio_val = r_mtime;
      2'd1:    w_mmio_val = r_mtimecmp;
      2'd2:    w_mmio_val = {31'd0, r_pending};
      default: w_mmio_val = r_tohost;
    endcase
  end

  assign w_mmio_rd = w_mapped ? (w_mmio_val & w_rmask) : 32'd0;

  // SRAM array: per-lane writes, read-before-write, contents survive reset.
  always_ff @(posedge clk) begin
    if (w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.dat_we[i]) r_mem[w_idx[AW-1:0]][8*i +: 8] <= bus.dat_wd[8*i +: 8];
      end
      if (|bus.dat_re) r_sram_q <= r_mem[w_idx[AW-1:0]];
    end
  end

  // Response path and MMIO registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sel_sram <= 1'b0;
      r_rmask    <= 32'd0;
      r_mmio_q   <= 32'd0;
      r_bus_err  <= 1'b0;
      r_mtime    <= 32'd0;
      r_mtimecmp <= 32'd0;
      r_tohost   <= 32'd0;
      r_pending  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_sel_sram <= w_in_range && (|bus.dat_re);
      r_rmask    <= w_rmask;
      r_mmio_q   <= w_mmio_rd;
      r_bus_err  <= w_err;
      r_mtime    <= w_mtime_n;
      r_mtimecmp <= w_cmp_n;
      r_tohost   <= w_tohost_n;
      r_pending  <= w_set || (r_pending && !w_clr);
      if (w_sel_tohost && (|bus.dat_we)) r_done <= 1'b1;
    end
  end

  assign bus.dat_rd  = r_sel_sram ? (r_sram_q & r_rmask) : r_mmio_q;
  assign bus.bus_err = r_bus_err;
  assign irq_timer   = r_pending;
  assign done        = r_done;
  assign tohost      = r_tohost;

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - self-checking bench for dmem_resp
module tb_dmem_resp;
  localparam logic [15:0] MB = 16'hFF00;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        irq_timer;
  logic        done;
  logic [31:0] tohost;

  dmem_resp_if bus ();

  dmem_resp #(.DEPTH(4096), .MMIO_BASE(MB)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .irq_timer (irq_timer),
    .done      (done),
    .tohost    (tohost)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [3:0]  re;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  exp_t sb[$];

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  // One bus cycle: expectation is queued when driven, popped when the response appears.
  task automatic acc(input string nm, input logic [15:0] a, input logic [3:0] we,
                     input logic [31:0] wd, input logic [3:0] re,
                     input logic [31:0] erd, input logic eerr);
    exp_t e;
    e.name = nm;
    e.rd   = erd;
    e.err  = eerr;
    sb.push_back(e);
    bus.dat_a  = a;
    bus.dat_we = we;
    bus.dat_wd = wd;
    bus.dat_re = re;
    @(posedge clk);
    #1;
    bus.dat_a  = '0;
    bus.dat_we = '0;
    bus.dat_wd = '0;
    bus.dat_re = '0;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard: got empty queue expected entry for %s", nm);
    end else begin
      e = sb.pop_front();
      chk32({e.name, " rd"}, bus.dat_rd, e.rd);
      chk1({e.name, " err"}, bus.bus_err, e.err);
    end
  endtask

  task automatic idle(input string nm);
    acc(nm, 16'h0, 4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];

    bus.dat_a  = '0;
    bus.dat_we = '0;
    bus.dat_wd = '0;
    bus.dat_re = '0;

    #1;
    chk32("reset rd", bus.dat_rd, 32'h0);
    chk1("reset err", bus.bus_err, 1'b0);
    chk1("reset irq", irq_timer, 1'b0);
    chk1("reset done", done, 1'b0);
    chk32("reset tohost", tohost, 32'h0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    vt.push_back('{"wr 0x10 full",   16'h0010, 4'hF, 32'hA1B2C3D4, 4'h0, 32'h0,        1'b0});
    vt.push_back('{"wr 0x10 lane2",  16'h0010, 4'h4, 32'h00FF0000, 4'h0, 32'h0,        1'b0});
    vt.push_back('{"rd 0x10 full",   16'h0010, 4'h0, 32'h0,        4'hF, 32'hA1FFC3D4, 1'b0});
    vt.push_back('{"rd 0x10 lo",     16'h0010, 4'h0, 32'h0,        4'h3, 32'h0000C3D4, 1'b0});
    vt.push_back('{"rd 0x10 hi",     16'h0012, 4'h0, 32'h0,        4'hC, 32'hA1FF0000, 1'b0});
    vt.push_back('{"wr 0x20",        16'h0020, 4'hF, 32'h11111111, 4'h0, 32'h0,        1'b0});
    vt.push_back('{"rw 0x20",        16'h0020, 4'hF, 32'h22222222, 4'hF, 32'h11111111, 1'b0});
    vt.push_back('{"rd 0x20",        16'h0020, 4'h0, 32'h0,        4'hF, 32'h22222222, 1'b0});
    vt.push_back('{"wr 0x0",         16'h0000, 4'hF, 32'h12345678, 4'h0, 32'h0,        1'b0});
    vt.push_back('{"rd oor 0x4000",  16'h4000, 4'h0, 32'h0,        4'hF, 32'h0,        1'b1});
    vt.push_back('{"idle",           16'h0000, 4'h0, 32'h0,        4'h0, 32'h0,        1'b0});
    vt.push_back('{"wr oor 0x4000",  16'h4000, 4'hF, 32'h0,        4'h0, 32'h0,        1'b1});
    vt.push_back('{"rd 0x0 kept",    16'h0000, 4'h0, 32'h0,        4'hF, 32'h12345678, 1'b0});
    vt.push_back('{"wr last word",   16'h3FFC, 4'hF, 32'hDEADBEEF, 4'h0, 32'h0,        1'b0});
    vt.push_back('{"rd last word",   16'h3FFC, 4'h0, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0});
    vt.push_back('{"rd mmio+0x40",   MB + 16'h40, 4'h0, 32'h0,     4'hF, 32'h0,        1'b1});
    vt.push_back('{"wr mmio+0x40",   MB + 16'h40, 4'hF, 32'hFFFFFFFF, 4'h0, 32'h0,     1'b1});
    vt.push_back('{"rd mmio+0x10",   MB + 16'h10, 4'h0, 32'h0,     4'hF, 32'h0,        1'b1});
    vt.push_back('{"rd status idle", MB + 16'h08, 4'h0, 32'h0,     4'hF, 32'h0,        1'b0});

    for (int i = 0; i < vt.size(); i++)
      acc(vt[i].name, vt[i].a, vt[i].we, vt[i].wd, vt[i].re, vt[i].rd, vt[i].err);

    chk32("tohost after bad wr", tohost, 32'h0);
    chk1("done before tohost", done, 1'b0);

    // Timer: mtime=100, compare=105, pending sets on the edge ending the cycle holding 105.
    acc("wr mtime 100", MB + 16'h00, 4'hF, 32'd100, 4'h0, 32'h0, 1'b0);
    acc("wr cmp 105",   MB + 16'h04, 4'hF, 32'd105, 4'hF, 32'h0, 1'b0);
    acc("rd mtime 101", MB + 16'h00, 4'h0, 32'h0,   4'hF, 32'd101, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle("timer wait");
      chk1("irq before match", irq_timer, 1'b0);
    end
    idle("timer match");
    chk1("irq at match", irq_timer, 1'b1);
    acc("rd status 1", MB + 16'h08, 4'h0, 32'h0, 4'hF, 32'h1, 1'b0);
    chk1("irq stays", irq_timer, 1'b1);
    acc("wr status clr", MB + 16'h08, 4'h1, 32'h1, 4'h0, 32'h0, 1'b0);
    chk1("irq cleared", irq_timer, 1'b0);
    acc("rd status 0", MB + 16'h08, 4'h0, 32'h0, 4'hF, 32'h0, 1'b0);

    acc("wr mtime near max", MB + 16'h00, 4'hF, 32'hFFFFFFFE, 4'h0, 32'h0, 1'b0);
    acc("rd mtime fffffffe", MB + 16'h00, 4'h0, 32'h0, 4'hF, 32'hFFFFFFFE, 1'b0);
    acc("rd mtime ffffffff", MB + 16'h00, 4'h0, 32'h0, 4'hF, 32'hFFFFFFFF, 1'b0);
    acc("rd mtime wrap 0",   MB + 16'h00, 4'h0, 32'h0, 4'hF, 32'h0, 1'b0);

    // tohost and sticky done.
    acc("wr tohost 1", MB + 16'h0C, 4'hF, 32'h1, 4'h0, 32'h0, 1'b0);
    chk1("done set", done, 1'b1);
    chk32("tohost 1", tohost, 32'h1);
    acc("wr tohost 0", MB + 16'h0C, 4'hF, 32'h0, 4'h0, 32'h0, 1'b0);
    chk1("done sticky", done, 1'b1);
    chk32("tohost 0", tohost, 32'h0);
    acc("wr tohost lane1", MB + 16'h0C, 4'h2, 32'h1234AB56, 4'h0, 32'h0, 1'b0);
    acc("rd tohost", MB + 16'h0C, 4'h0, 32'h0, 4'hF, 32'h0000AB00, 1'b0);

    // Reset mid-run with timer pending and tohost set.
    acc("wr mtime 50", MB + 16'h00, 4'hF, 32'd50, 4'h0, 32'h0, 1'b0);
    acc("wr cmp 52",   MB + 16'h04, 4'hF, 32'd52, 4'h0, 32'h0, 1'b0);
    idle("pre reset 51");
    idle("pre reset 52");
    chk1("irq before reset", irq_timer, 1'b1);
    acc("wr tohost 5", MB + 16'h0C, 4'hF, 32'h5, 4'h0, 32'h0, 1'b0);
    chk32("tohost 5", tohost, 32'h5);
    acc("rd 0x10 pre reset", 16'h0010, 4'h0, 32'h0, 4'hF, 32'hA1FFC3D4, 1'b0);
    rstn = 1'b0;
    #1;
    chk32("mid reset rd", bus.dat_rd, 32'h0);
    chk1("mid reset irq", irq_timer, 1'b0);
    chk1("mid reset done", done, 1'b0);
    chk32("mid reset tohost", tohost, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    acc("rd mtime after reset", MB + 16'h00, 4'h0, 32'h0, 4'hF, 32'h0, 1'b0);
    acc("rd mtime next",        MB + 16'h00, 4'h0, 32'h0, 4'hF, 32'h1, 1'b0);
    acc("rd cmp after reset",   MB + 16'h04, 4'h0, 32'h0, 4'hF, 32'h0, 1'b0);
    acc("rd status after reset", MB + 16'h08, 4'h0, 32'h0, 4'hF, 32'h0, 1'b0);
    acc("rd 0x10 after reset",  16'h0010, 4'h0, 32'h0, 4'hF, 32'hA1FFC3D4, 1'b0);
    chk1("irq after reset", irq_timer, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
